// File: rtl/qsgmii_tx_lane_mux.sv
// QSGMII transmit lane aggregator: lane-0 K28.5->K28.1 marker, running-disparity tracking, idle D5.6/D16.2 fixup.
// Optional fixup statistics counter enabled by macro QSGMII_TX_FIXUP_STATS_EN.
module qsgmii_tx_lane_mux #(
    parameter bit LANE0_K28_1 = 1'b1,
    parameter bit IDLE_FIXUP  = 1'b1
) (
    input  logic        tx_clk,
    input  logic        tx_reset,
    input  logic [31:0] port_data,
    input  logic [3:0]  port_is_k,
    output logic [31:0] serdes_data,
`ifdef QSGMII_TX_FIXUP_STATS_EN
    output logic [15:0] fixup_count,
`endif
    output logic [3:0]  serdes_is_k,
    output logic        rd_positive
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    logic [31:0] data_q, data_d;
    logic [3:0]  is_k_q, is_k_d;
    logic        rd_q, rd_d;
    logic [3:0]  prev_k285_q, prev_k285_d;
    logic [2:0]  fix_lanes;

    // A byte flips disparity when exactly one of its 6b/4b sub-blocks is unbalanced.
    function automatic logic rd_flip(input logic [7:0] b, input logic k);
        logic u6;
        logic u4;
        case (b[4:0])
            5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
            5'd24, 5'd27, 5'd29, 5'd30, 5'd31: u6 = 1'b1;
            5'd28:                             u6 = k;
            default:                           u6 = 1'b0;
        endcase
        u4 = (b[7:5] == 3'd0) || (b[7:5] == 3'd4) || (b[7:5] == 3'd7);
        return u6 ^ u4;
    endfunction

    always_comb begin
        logic       rd;
        logic [7:0] in_b;
        logic [7:0] out_b;
        logic       k;
        logic       is_k285;
        data_d      = '0;
        is_k_d      = port_is_k;
        prev_k285_d = '0;
        fix_lanes   = '0;
        rd          = rd_q;
        for (int p = 0; p < 4; p++) begin
            in_b    = port_data[8*p +: 8];
            k       = port_is_k[p];
            is_k285 = k && (in_b == K28_5);
            out_b   = in_b;
            if (LANE0_K28_1 && (p == 0) && is_k285)
                out_b = K28_1;
            if (IDLE_FIXUP && prev_k285_q[p] && !k && ((in_b == D5_6) || (in_b == D16_2))) begin
                out_b = rd ? D16_2 : D5_6;
                if (out_b != in_b)
                    fix_lanes = fix_lanes + 3'd1;
            end
            rd                  = rd ^ rd_flip(out_b, k);
            data_d[8*p +: 8]    = out_b;
            prev_k285_d[p]      = is_k285;
        end
        rd_d = rd;
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            data_q      <= '0;
            is_k_q      <= '0;
            rd_q        <= 1'b0;
            prev_k285_q <= '0;
        end else begin
            data_q      <= data_d;
            is_k_q      <= is_k_d;
            rd_q        <= rd_d;
            prev_k285_q <= prev_k285_d;
        end
    end

    assign serdes_data = data_q;
    assign serdes_is_k = is_k_q;
    assign rd_positive = rd_q;

`ifdef QSGMII_TX_FIXUP_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    // Saturating: the sum is one bit wider so overflow is detectable.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {14'd0, fix_lanes};
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign fixup_count = cnt_q;
`else
    logic unused_fix;
    assign unused_fix = ^fix_lanes;
`endif

endmodule

// File: tb/tb_qsgmii_tx_lane_mux.sv
// Directed-vector bench for qsgmii_tx_lane_mux: default instance plus a pass-through instance (both features off).
// Exercises the fixup counter when QSGMII_TX_FIXUP_STATS_EN is defined.
module tb_qsgmii_tx_lane_mux;

    logic        tx_clk = 1'b0;
    logic        tx_reset;
    logic [31:0] port_data;
    logic [3:0]  port_is_k;
    logic [31:0] serdes_data, pt_data;
    logic [3:0]  serdes_is_k, pt_is_k;
    logic        rd_positive, pt_rd;
`ifdef QSGMII_TX_FIXUP_STATS_EN
    logic [15:0] fixup_count, pt_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 tx_clk = ~tx_clk;

    qsgmii_tx_lane_mux dut (
        .tx_clk      (tx_clk),
        .tx_reset    (tx_reset),
        .port_data   (port_data),
        .port_is_k   (port_is_k),
        .serdes_data (serdes_data),
`ifdef QSGMII_TX_FIXUP_STATS_EN
        .fixup_count (fixup_count),
`endif
        .serdes_is_k (serdes_is_k),
        .rd_positive (rd_positive)
    );

    qsgmii_tx_lane_mux #(.LANE0_K28_1(1'b0), .IDLE_FIXUP(1'b0)) dut_pt (
        .tx_clk      (tx_clk),
        .tx_reset    (tx_reset),
        .port_data   (port_data),
        .port_is_k   (port_is_k),
        .serdes_data (pt_data),
`ifdef QSGMII_TX_FIXUP_STATS_EN
        .fixup_count (pt_count),
`endif
        .serdes_is_k (pt_is_k),
        .rd_positive (pt_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one word, wait one clock, check both instances; the pass-through instance must echo its input.
    task automatic step(input string tag, input logic [31:0] d, input logic [3:0] k,
                        input logic [31:0] exp_d, input logic exp_rd, input logic exp_rd_pt);
        port_data = d;
        port_is_k = k;
        @(posedge tx_clk);
        #1;
        chk({tag, " data"}, serdes_data, exp_d);
        chk({tag, " is_k"}, {28'd0, serdes_is_k}, {28'd0, k});
        chk({tag, " rd"}, {31'd0, rd_positive}, {31'd0, exp_rd});
        chk({tag, " pt data"}, pt_data, d);
        chk({tag, " pt is_k"}, {28'd0, pt_is_k}, {28'd0, k});
        chk({tag, " pt rd"}, {31'd0, pt_rd}, {31'd0, exp_rd_pt});
    endtask

    initial begin
        tx_reset  = 1'b1;
        port_data = 32'hFFFF_FFFF;
        port_is_k = 4'hF;
        repeat (2) @(posedge tx_clk);
        #1;
        chk("rst data", serdes_data, 32'h0);
        chk("rst is_k", {28'd0, serdes_is_k}, 32'h0);
        chk("rst rd", {31'd0, rd_positive}, 32'h0);
        chk("rst pt rd", {31'd0, pt_rd}, 32'h0);
        tx_reset = 1'b0;

        // Idle pair on all lanes: marker on lane 0, D16.2 rewritten to D5.6 under negative RD.
        step("v1 K28.5 x4", 32'hBCBC_BCBC, 4'hF, 32'hBCBC_BC3C, 1'b0, 1'b0);
        step("v2 D16.2 x4", 32'h5050_5050, 4'h0, 32'hC5C5_C5C5, 1'b0, 1'b0);
        step("v3 zeros",    32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 1'b0);
        // Positive RD after lane-0 K28.1: D5.6 becomes D16.2.
        step("v4 K lane0",  32'h0000_00BC, 4'h1, 32'h0000_003C, 1'b1, 1'b1);
        step("v5 D5.6->50", 32'h0000_00C5, 4'h0, 32'h0000_0050, 1'b0, 1'b1);
        // D3.0 flips RD back inside the same word.
        step("v6 K+D3.0",   32'h0000_03BC, 4'h1, 32'h0000_033C, 1'b0, 1'b1);
        step("v7 D5.6 keep",32'h0000_00C5, 4'h0, 32'h0000_00C5, 1'b0, 1'b1);
        // /C/ second symbol passes untouched.
        step("v8 cfg K",    32'h0000_00BC, 4'h1, 32'h0000_003C, 1'b1, 1'b0);
        step("v9 cfg B5",   32'h0000_00B5, 4'h0, 32'h0000_00B5, 1'b1, 1'b0);
        // Lane 1 K28.5 is never substituted; its idle fixup uses RD after lane 0.
        step("v10 K lane1", 32'h0000_BC00, 4'h2, 32'h0000_BC00, 1'b0, 1'b1);
        step("v11 lane1 fix",32'h0000_5000, 4'h0, 32'h0000_C500, 1'b0, 1'b0);
        // Intra-word RD chain: D3.0 on lane 1 makes lane 2 see positive RD.
        step("v12 K lanes0,2",32'h00BC_00BC, 4'h5, 32'h00BC_003C, 1'b0, 1'b0);
        step("v13 chain",   32'h00C5_03C5, 4'h0, 32'h0050_03C5, 1'b0, 1'b1);

        // Reset while a lane-0 K28.5 is in flight clears RD and the idle history.
        step("v14 pre-rst", 32'h0000_00BC, 4'h1, 32'h0000_003C, 1'b1, 1'b0);
        tx_reset  = 1'b1;
        port_data = 32'h0000_00BC;
        port_is_k = 4'h1;
        @(posedge tx_clk);
        #1;
        chk("midrst data", serdes_data, 32'h0);
        chk("midrst is_k", {28'd0, serdes_is_k}, 32'h0);
        chk("midrst rd", {31'd0, rd_positive}, 32'h0);
        chk("midrst pt rd", {31'd0, pt_rd}, 32'h0);
        tx_reset = 1'b0;
        step("v15 post-rst",32'h0000_00C5, 4'h0, 32'h0000_00C5, 1'b0, 1'b0);

        // Illegal K codes still follow the flip rule: K-flagged 0x1C is balanced, data 0x1C is not.
        step("v16 K 1C",    32'h0000_001C, 4'h1, 32'h0000_001C, 1'b0, 1'b0);
        step("v17 D 1C",    32'h0000_001C, 4'h0, 32'h0000_001C, 1'b1, 1'b1);

`ifdef QSGMII_TX_FIXUP_STATS_EN
        tx_reset = 1'b1;
        @(posedge tx_clk);
        #1;
        chk("cnt rst", {16'd0, fixup_count}, 32'h0);
        tx_reset = 1'b0;
        for (int r = 1; r <= 16400; r++) begin
            port_data = 32'hBCBC_BCBC;
            port_is_k = 4'hF;
            @(posedge tx_clk);
            port_data = 32'h5050_5050;
            port_is_k = 4'h0;
            @(posedge tx_clk);
            #1;
            if (r == 1)     chk("cnt first", {16'd0, fixup_count}, 32'd4);
            if (r == 2)     chk("cnt second", {16'd0, fixup_count}, 32'd8);
            if (r == 16383) chk("cnt near sat", {16'd0, fixup_count}, 32'd65532);
            if (r == 16384) chk("cnt sat", {16'd0, fixup_count}, 32'hFFFF);
        end
        chk("cnt hold", {16'd0, fixup_count}, 32'hFFFF);
        chk("pt cnt", {16'd0, pt_count}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
